// File: rtl/muldiv_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_arbiter_if
// Brief    : Handshake/operand bus between the lane arbiter and the shared
//            multiply/divide unit.
// Revision : 1.0
// ============================================================================
interface muldiv_arbiter_if #(
  parameter int W = 32
);
  logic         unit_start;
  logic [W-1:0] unit_a;
  logic [W-1:0] unit_b;
  logic         unit_div;
  logic         unit_signed;
  logic         unit_kill;
  logic         unit_done;
  logic [W-1:0] unit_hi;
  logic [W-1:0] unit_lo;

  modport master (
    output unit_start, unit_a, unit_b, unit_div, unit_signed, unit_kill,
    input  unit_done, unit_hi, unit_lo
  );

  modport slave (
    input  unit_start, unit_a, unit_b, unit_div, unit_signed, unit_kill,
    output unit_done, unit_hi, unit_lo
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_arbiter
// Brief    : Sequences the shared mul/div unit between two execute lanes,
//            older lane 1 first, and holds each lane's HI/LO until advance.
// Revision : 1.0
// ============================================================================
module muldiv_arbiter #(
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           advance,
  input  logic [1:0]     req,
  input  logic [1:0]     is_div,
  input  logic [1:0]     is_signed,
  input  logic [W-1:0]   srca1,
  input  logic [W-1:0]   srcb1,
  input  logic [W-1:0]   srca0,
  input  logic [W-1:0]   srcb0,
  muldiv_arbiter_if.master unit,
  output logic [1:0]     done,
  output logic [W-1:0]   hi1,
  output logic [W-1:0]   lo1,
  output logic [W-1:0]   hi0,
  output logic [W-1:0]   lo0,
  output logic           busy,
  output logic           err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lane;
  logic [1:0]       w_pending;
  logic             w_other_pending;

  assign w_pending       = req & ~done;
  assign busy            = |w_pending;
  assign w_other_pending = r_lane ? w_pending[0] : w_pending[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_lane           <= 1'b0;
      done             <= 2'b00;
      hi1              <= '0;
      lo1              <= '0;
      hi0              <= '0;
      lo0              <= '0;
      err              <= 1'b0;
      unit.unit_start  <= 1'b0;
      unit.unit_kill   <= 1'b0;
      unit.unit_a      <= '0;
      unit.unit_b      <= '0;
      unit.unit_div    <= 1'b0;
      unit.unit_signed <= 1'b0;
    end else begin
      unit.unit_start <= 1'b0;
      unit.unit_kill  <= 1'b0;
      if (flush) begin
        // A unit_done landing with the flush is dropped along with the work.
        r_state        <= IDLE;
        r_cnt          <= '0;
        done           <= 2'b00;
        unit.unit_kill <= (r_state == RUN);
      end else begin
        case (r_state)
          IDLE: begin
            if (|w_pending) begin
              r_lane           <= w_pending[1];
              unit.unit_a      <= w_pending[1] ? srca1 : srca0;
              unit.unit_b      <= w_pending[1] ? srcb1 : srcb0;
              unit.unit_div    <= w_pending[1] ? is_div[1] : is_div[0];
              unit.unit_signed <= w_pending[1] ? is_signed[1] : is_signed[0];
              unit.unit_start  <= 1'b1;
              r_cnt            <= '0;
              r_state          <= RUN;
            end else if (|req) begin
              r_state <= HOLD;
            end
          end
          RUN: begin
            if (unit.unit_done) begin
              if (r_lane) begin
                hi1     <= unit.unit_hi;
                lo1     <= unit.unit_lo;
                done[1] <= 1'b1;
              end else begin
                hi0     <= unit.unit_hi;
                lo0     <= unit.unit_lo;
                done[0] <= 1'b1;
              end
              r_state <= w_other_pending ? IDLE : HOLD;
            end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
              // Hung op: abort and let IDLE re-grant the same lane.
              err            <= 1'b1;
              unit.unit_kill <= 1'b1;
              r_cnt          <= '0;
              r_state        <= IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          HOLD: begin
            if (advance) begin
              done    <= 2'b00;
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/muldiv_arbiter.md
Name: muldiv_arbiter

Overview:
- Sequences the single shared multiply/divide unit between the two execute-stage lanes of the dual-issue in-order pipeline.
- Lane 1 carries the older instruction, so it is served first. Lane 0 is then served back-to-back when both lanes request.
- Captures each lane's HI/LO result and holds it until the pipeline advances.
- Aborts the unit on a pipeline flush and flags a hung operation.

Parameters:
- W, 32, operand/result width.
- TIMEOUT, 64, max cycles from unit_start to unit_done before err is raised.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  execute-stage flush; discards all in-flight/held work.
- advance  in  1  execute stage advances this cycle (consumes held results).
- req  in  2  per-lane mul/div request; held high until advance.
- is_div  in  2  per-lane: 1 = divide, 0 = multiply.
- is_signed  in  2  per-lane signedness.
- srca1, srcb1, srca0, srcb0  in  W each  per-lane operands.
- unit_start  out  1  one-cycle start pulse to the shared unit.
- unit_a, unit_b  out  W  registered operands for the unit.
- unit_div, unit_signed  out  1  registered op select.
- unit_kill  out  1  one-cycle abort pulse to the unit.
- unit_done  in  1  unit result valid (one-cycle pulse).
- unit_hi, unit_lo  in  W  unit result.
- done  out  2  per-lane result valid.
- hi1, lo1, hi0, lo0  out  W  per-lane held results.
- busy  out  1  a lane is requesting and not yet done.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0, including result registers, err and cur_lane.
- States: IDLE, RUN, HOLD.
- IDLE, pending = req & ~done:
  - If pending is nonzero, grant lane = pending[1] ? 1 : 0.
  - Register operands and op of the granted lane; assert unit_start next cycle (1-cycle pulse); go to RUN; clear the timeout counter.
  - If pending is zero but req is nonzero (all requested lanes done), go to HOLD.
- RUN:
  - Counter increments each cycle.
  - On unit_done: capture unit_hi/unit_lo into the granted lane's registers; set done[lane] next cycle.
  - Then go to IDLE if the other lane is still pending, otherwise to HOLD.
  - If the counter reaches TIMEOUT without unit_done: set err (sticky until reset), pulse unit_kill, go to IDLE without setting done.
- HOLD:
  - done and results stay stable.
  - On advance: clear done[1:0], go to IDLE.
  - advance in any other state has no effect.
- Latency:
  - req rises in IDLE at cycle n → unit_start at n+1.
  - unit_done at cycle k → done[lane] and result visible at k+1.
  - Two-lane case: lane 0 unit_start at k+2.
- busy = |(req & ~done), combinational.
- Flush (highest priority, any state):
  - Next state IDLE; done cleared; counter cleared.
  - unit_kill pulses one cycle if state was RUN.
  - A unit_done coincident with flush is discarded.
  - No unit_start is issued in the flush cycle.
- A req deasserted while a lane is in RUN does not abort the operation; the result is still captured.
- unit_start and unit_kill are never asserted in the same cycle.
- err does not block further grants.

Test Plan:
- Lane 1 only: req=10, is_div=0, signed, srca1=-3, srcb1=7; unit_done 4 cycles after start with hi=FFFFFFFF, lo=FFFFFFEB → done=10, hi1/lo1 match; held until advance, then done=00.
- Both lanes: req=11, lane1 div 100/7, lane0 mul 5×6 → first unit_start carries 100,7,div=1; lane0 start occurs 1 cycle after done[1] rises; final done=11, lo1=14, hi1=2, lo0=30.
- Flush during RUN: lane0 mul started, flush 2 cycles later → unit_kill pulse, state IDLE, done=00; later unit_done ignored.
- Flush coincident with unit_done → done stays 00, no capture, next req starts a fresh unit_start.
- Timeout with TIMEOUT=8: unit_done never comes → err=1 exactly 8 cycles after unit_start, unit_kill pulses, lane re-granted next IDLE.
- Async reset asserted mid-RUN → all outputs 0 immediately, no unit_start after release until req is sampled.
